// File: rtl/sata_txcrc.sv
// sata_txcrc -- SATA transmit CRC stage.
//   Passes each AXI-stream FIS through with one cycle of latency. It computes the
//   SATA CRC32 (poly 0x04C11DB7, MSB first, seeded with CRC_SEED, no final XOR)
//   over every dword of the frame. It then appends the CRC as a trailing dword
//   that carries M_LAST.
//   Backpressure: the output register reloads only when it is empty or
//   M_READY is high. S_READY drops for one cycle per frame while the CRC
//   dword is emitted.
// Ports:
//   i_clk, i_reset_n              clock, async active-low reset
//   S_VALID/S_READY/S_DATA/S_LAST upstream frame dwords (header first)
//   M_VALID/M_READY/M_DATA/M_LAST downstream dwords; M_LAST marks the CRC dword
//   o_err_len                     only with SATA_TXCRC_LENCHK_EN: one-cycle pulse
//                                 when a frame exceeds 2049 dwords
// Optional feature macro: SATA_TXCRC_LENCHK_EN (frame length checker).
module sata_txcrc #(
   parameter logic [31:0] CRC_SEED     = 32'h5232_5032,
   parameter bit          OPT_LOWPOWER = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [31:0] S_DATA,
   input  logic        S_LAST,
   output logic        M_VALID,
   input  logic        M_READY,
   output logic [31:0] M_DATA,
   output logic        M_LAST
`ifdef SATA_TXCRC_LENCHK_EN
   ,
   output logic        o_err_len
`endif
);

   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

   typedef enum logic [0:0] {
      ST_DATA = 1'b0,
      ST_CRC  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_last_q, m_last_d;
   logic        ovl;
   logic        accept;

   // One dword is folded in one cycle: 32 serial LFSR steps, data bit 31 first.
   function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                            input logic [31:0] dat);
      logic [31:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ dat[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return c;
   endfunction

   // The output register may take a new value when it is empty or being drained.
   assign ovl     = !m_valid_q || M_READY;
   assign S_READY = ovl && (state_q == ST_DATA);
   assign accept  = S_VALID && S_READY;

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;

      if (ovl) begin
         unique case (state_q)
            ST_DATA: begin
               if (accept) begin
                  m_valid_d = 1'b1;
                  m_data_d  = S_DATA;
                  m_last_d  = 1'b0;
                  crc_d     = crc_step(crc_q, S_DATA);
                  if (S_LAST) begin
                     state_d = ST_CRC;
                  end
               end else begin
                  m_valid_d = 1'b0;
                  if (OPT_LOWPOWER) begin
                     m_data_d = 32'h0;
                     m_last_d = 1'b0;
                  end
               end
            end
            ST_CRC: begin
               // The CRC dword is never folded back into the register.
               m_valid_d = 1'b1;
               m_data_d  = crc_q;
               m_last_d  = 1'b1;
               crc_d     = CRC_SEED;
               state_d   = ST_DATA;
            end
            default: begin
               state_d = ST_DATA;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_DATA;
         crc_q     <= CRC_SEED;
         m_valid_q <= 1'b0;
         m_data_q  <= 32'h0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

   assign M_VALID = m_valid_q;
   assign M_DATA  = m_data_q;
   assign M_LAST  = m_last_q;

`ifdef SATA_TXCRC_LENCHK_EN
   // Length check: a frame is at most a header plus 2048 payload dwords.
   localparam logic [11:0] MAX_DW = 12'd2049;

   logic [11:0] len_cnt_q, len_cnt_d;
   logic        sof_q, sof_d;
   logic        err_len_q, err_len_d;

   always_comb begin
      len_cnt_d = len_cnt_q;
      sof_d     = sof_q;
      err_len_d = 1'b0;
      if (accept) begin
         sof_d = S_LAST;
         if (sof_q) begin
            len_cnt_d = 12'd1;
         end else if (len_cnt_q <= MAX_DW) begin
            // The counter stops one past the limit, so each frame pulses once.
            len_cnt_d = len_cnt_q + 12'd1;
            err_len_d = (len_cnt_q == MAX_DW);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         len_cnt_q <= 12'd0;
         sof_q     <= 1'b1;
         err_len_q <= 1'b0;
      end else begin
         len_cnt_q <= len_cnt_d;
         sof_q     <= sof_d;
         err_len_q <= err_len_d;
      end
   end

   assign o_err_len = err_len_q;
`endif

endmodule

// File: tb/tb_sata_txcrc.sv
// tb_sata_txcrc -- randomized scoreboard bench for sata_txcrc.
//   The driver pushes the expected output beats, and a monitor pops and compares them.
//   A byte-table CRC model supplies the reference CRC dwords.
module tb_sata_txcrc;

   localparam logic [31:0] SEED = 32'h5232_5032;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;

   logic        i_clk;
   logic        i_reset_n;
   logic        S_VALID;
   logic        S_READY;
   logic [31:0] S_DATA;
   logic        S_LAST;
   logic        M_VALID;
   logic        M_READY;
   logic [31:0] M_DATA;
   logic        M_LAST;
`ifdef SATA_TXCRC_LENCHK_EN
   logic        o_err_len;
`endif

   sata_txcrc dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .S_VALID   (S_VALID),
      .S_READY   (S_READY),
      .S_DATA    (S_DATA),
      .S_LAST    (S_LAST),
      .M_VALID   (M_VALID),
      .M_READY   (M_READY),
      .M_DATA    (M_DATA),
      .M_LAST    (M_LAST)
`ifdef SATA_TXCRC_LENCHK_EN
      ,
      .o_err_len (o_err_len)
`endif
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   bit          rand_rdy = 0;
   logic [32:0] exp_q[$];
   int          beat_cyc[$];
   logic [31:0] crc_tab[256];
   logic [31:0] mcrc;
   bit          hold_pend = 0;
   logic [32:0] hold_val;
   int          err_pulses = 0;
   int          err_at = -1;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference CRC: bytewise table method, most significant byte first.
   function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [31:0] w);
      logic [31:0] r;
      logic [7:0]  b;
      r = c;
      for (int k = 3; k >= 0; k--) begin
         b = w[8*k +: 8];
         r = (r << 8) ^ crc_tab[r[31:24] ^ b];
      end
      return r;
   endfunction

   // Downstream ready: always high, or randomly stalling about a quarter of cycles.
   initial begin
      M_READY = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         M_READY = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor: samples on the falling edge, when all inputs are stable.
   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         hold_pend = 0;
      end else begin
         if (hold_pend) begin
            chk("stall_vld", M_VALID, 1);
            chk("stall_hold", {M_LAST, M_DATA}, hold_val);
         end
         if (M_VALID && M_READY) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h expected no beat", {M_LAST, M_DATA});
            end else begin
               chk("beat", {M_LAST, M_DATA}, exp_q.pop_front());
            end
         end
         hold_pend = M_VALID && !M_READY;
         hold_val  = {M_LAST, M_DATA};
`ifdef SATA_TXCRC_LENCHK_EN
         if (o_err_len) begin
            err_pulses++;
            err_at = n_acc;
         end
`endif
      end
   end

   // Present one word and hold it until accepted. Returns just after the accepting edge.
   task automatic drive_word(input logic [31:0] d, input logic l);
      bit ok;
      ok = 0;
      S_VALID = 1'b1;
      S_DATA  = d;
      S_LAST  = l;
      for (int t = 0; t < 500; t++) begin
         @(negedge i_clk);
         if (S_READY) begin
            ok = 1;
            break;
         end
         @(posedge i_clk);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no S_READY expected accept of %0h", d);
      end
      @(posedge i_clk);
      #1;
      n_acc++;
      exp_q.push_back({1'b0, d});
      mcrc = model_crc(mcrc, d);
      if (l) begin
         exp_q.push_back({1'b1, mcrc});
         mcrc = SEED;
      end
   endtask

   task automatic send_frame(input int len, input bit idle_after, input bit gaps);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            S_VALID = 1'b0;
            @(posedge i_clk);
            #1;
         end
         drive_word($urandom, i == len - 1);
      end
      if (idle_after) S_VALID = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge i_clk);
      chk("drain_left", exp_q.size(), 0);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      for (int i = 0; i < 256; i++) begin
         r = i << 24;
         for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
         crc_tab[i] = r;
      end
      mcrc      = SEED;
      i_reset_n = 1'b0;
      S_VALID   = 1'b1;
      S_DATA    = 32'hA5A5_0001;
      S_LAST    = 1'b0;

      // Reset state, with S_VALID held high.
      repeat (3) @(negedge i_clk);
      chk("rst_m_valid", M_VALID, 0);
      chk("rst_m_last", M_LAST, 0);
      chk("rst_m_data", M_DATA, 0);
      chk("rst_s_ready", S_READY, 1);
      @(posedge i_clk);
      #1;
      S_VALID   = 1'b0;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Single-dword frame, followed by a one-cycle S_READY bubble.
      drive_word(32'h0000_0046, 1'b1);
      S_VALID = 1'b0;
      @(negedge i_clk);
      chk("first_out_vld", M_VALID, 1);
      chk("bubble_s_ready", S_READY, 0);
      @(negedge i_clk);
      chk("after_bubble_s_ready", S_READY, 1);
      drain();

      // Three-dword frame with random downstream stalls.
      rand_rdy = 1;
      drive_word(32'h0000_0046, 1'b0);
      drive_word(32'h1122_3344, 1'b0);
      drive_word(32'hDEAD_BEEF, 1'b1);
      S_VALID = 1'b0;
      drain();

      // Random frames, with stalls and input gaps.
      for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 7), 1, 1);
      drain();

      // Two back-to-back 3-dword frames at full rate: 8 beats in 8 consecutive cycles.
      rand_rdy = 0;
      @(posedge i_clk);
      #1;
      beat_cyc.delete();
      send_frame(3, 0, 0);
      send_frame(3, 1, 0);
      drain();
      chk("b2b_beats", beat_cyc.size(), 8);
      if (beat_cyc.size() == 8) chk("b2b_span", beat_cyc[7] - beat_cyc[0], 7);

      // Reset after 2 of 5 words: outputs clear at once, and the partial frame is dropped.
      drive_word($urandom, 1'b0);
      drive_word($urandom, 1'b0);
      S_VALID   = 1'b0;
      i_reset_n = 1'b0;
      #1;
      chk("midrst_m_valid", M_VALID, 0);
      chk("midrst_m_last", M_LAST, 0);
      exp_q.delete();
      mcrc = SEED;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      drive_word(32'h0000_0046, 1'b1);
      S_VALID = 1'b0;
      drain();

`ifdef SATA_TXCRC_LENCHK_EN
      // A 2050-dword frame pulses once, on the 2050th accept. A 2049-dword frame does not pulse.
      err_pulses = 0;
      n_acc = 0;
      send_frame(2050, 1, 0);
      drain();
      chk("len2050_pulses", err_pulses, 1);
      chk("len2050_at", err_at, 2050);
      err_pulses = 0;
      n_acc = 0;
      send_frame(2049, 1, 0);
      drain();
      chk("len2049_pulses", err_pulses, 0);
`endif

      repeat (3) @(posedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sata_txcrc.md
Name: sata_txcrc

Overview:
- Transmit-path stage directly downstream of the DATA-FIS framer. Each incoming AXI-stream frame is one FIS (header dword first, S_LAST on the final payload dword).
- Passes each frame through unchanged, computes the SATA CRC32 over every dword of the frame, and appends the CRC as one extra trailing dword carrying M_LAST.
- Output feeds the scrambler/link-layer primitive inserter.

Parameters:
- CRC_SEED, 32'h5232_5032, CRC register value at the start of every frame.
- OPT_LOWPOWER, 1'b0, when 1 M_DATA is forced to 0 whenever M_VALID is 0.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to i_clk.
- S_VALID  input  1  upstream word valid.
- S_READY  output  1  this block accepts the S_DATA word.
- S_DATA  input  32  frame dword; header dword first.
- S_LAST  input  1  final dword of the frame.
- M_VALID  output  1  output word valid.
- M_READY  input  1  downstream accepts the word.
- M_DATA  output  32  frame dword, or the CRC dword.
- M_LAST  output  1  set only on the CRC dword.
- o_err_len  output  1  present only with SATA_TXCRC_LENCHK_EN; single-cycle error pulse.

Behaviour:
- Reset (async, i_reset_n=0):
  - state=DATA, crc=CRC_SEED.
  - M_VALID=0, M_LAST=0, M_DATA=0, o_err_len=0.
  - S_READY follows its combinational equation from these values, so it reads 1 during reset.
- Output register: M_VALID/M_DATA/M_LAST are registered and may load only when (!M_VALID || M_READY) ("ovl"). M_DATA and M_LAST are held stable while M_VALID && !M_READY.
- S_READY = ovl && (state==DATA), combinational. Accept = S_VALID && S_READY.
- State DATA:
  - On accept: M_VALID<=1, M_DATA<=S_DATA, M_LAST<=0, crc<=crc_step(crc,S_DATA).
  - If S_LAST is also set on that beat, state<=CRC.
  - On ovl without an accept: M_VALID<=0.
- State CRC:
  - S_READY=0. On ovl: M_VALID<=1, M_DATA<=crc, M_LAST<=1, crc<=CRC_SEED, state<=DATA.
- Latency: 1 cycle from S to M. Each frame of N input dwords produces N+1 output dwords.
- Bubble: exactly one input bubble per frame, during the CRC state. Back-to-back frames at full M_READY therefore run at N+1 cycles per frame.
- crc_step:
  - Generator polynomial 0x04C11DB7, non-reflected.
  - Dword is processed bit 31 first: 32 serial shift iterations, unrolled combinationally into one cycle.
  - No final XOR, no bit reversal of the result.
- The CRC covers every input dword of the frame, header included. The CRC dword itself is not fed back into crc.
- Single-dword frame (S_VALID && S_LAST on the first word): output is that word, then the CRC. Legal.
- M_READY low while in CRC state: stay in CRC; the CRC dword loads when ovl becomes 1. The pending data word stays held meanwhile.
- Reset mid-frame: crc returns to seed and the partial frame output is discarded. The next accepted word is treated as a header.
- OPT_LOWPOWER=1: whenever the output register loads with M_VALID<=0, M_DATA<=0 and M_LAST<=0.

Optional Feature:
- Macro: SATA_TXCRC_LENCHK_EN.
- With the macro defined:
  - An 12-bit per-frame dword counter clears on the first accept and on reset.
  - If an accept would make the count exceed 2049 (header + 2048 payload dwords), o_err_len pulses high for exactly one cycle.
  - The counter saturates, so there is one pulse per offending frame.
  - Data flow and CRC are unaffected.
- Without the macro: no o_err_len port and no counter logic.

Test Plan:
- Reset-time values: hold i_reset_n=0, S_VALID=1 -> M_VALID=0, M_LAST=0, S_READY=1 (combinational from reset state); nothing is accepted while reset is asserted. Release reset -> first accepted word appears next cycle with M_LAST=0.
- Single-dword frame 0x0000_0046 with S_LAST=1, M_READY=1 -> out 0x0000_0046 (M_LAST=0) then the golden-model CRC dword with M_LAST=1. S_READY=0 for exactly 1 cycle.
- Frame 0x0000_0046, 0x1122_3344, 0xDEAD_BEEF (last), random M_READY stalls -> 4 output words, data matching in order. M_DATA/M_LAST stable during every stall. CRC equals the golden model.
- Two back-to-back 3-dword frames, M_READY=1, S_VALID=1 continuously -> 8 output beats in 8 cycles after the first. The second CRC is computed from seed, independent of frame 1.
- Assert reset mid-frame after 2 of 5 words -> outputs clear at once. A subsequent 1-dword frame yields the same CRC as in the single-dword test.
- With SATA_TXCRC_LENCHK_EN: 2050-dword frame -> o_err_len pulses once on the 2050th accept. A 2049-dword frame -> no pulse.
